// File: rtl/cost_eval_sequencer_if.sv
// Request/result bundle between the packet-handling requester and the
// cost-evaluation sequencer.
interface cost_eval_sequencer_if #(
  parameter int NUM_SINKS = 10,
  parameter int ID_W      = 5,
  parameter int IDX_W     = 4
);
  logic                      start;
  logic                      abort;
  logic [ID_W-1:0]           arg_id;
  logic [ID_W-1:0]           my_node_id;
  logic [ID_W-1:0]           dest_id;
  logic [NUM_SINKS*ID_W-1:0] known_sinks;
  logic [NUM_SINKS-1:0]      sink_valid;
  logic                      busy;
  logic                      done;
  logic                      iam_sink;
  logic                      iam_forwarding;
  logic [IDX_W-1:0]          sink_index;

  modport master (
    output start, abort, arg_id, my_node_id, dest_id, known_sinks, sink_valid,
    input  busy, done, iam_sink, iam_forwarding, sink_index
  );

  modport slave (
    input  start, abort, arg_id, my_node_id, dest_id, known_sinks, sink_valid,
    output busy, done, iam_sink, iam_forwarding, sink_index
  );
endinterface

// File: rtl/cost_eval_sequencer.sv
// One start/busy/done controlled cost-evaluation pass: latch the request,
// scan the known-sink table one entry per clock (first match wins), run the
// forwarding-node check, then pulse done. Results hold until the next start.
module cost_eval_sequencer #(
  parameter int NUM_SINKS = 10,
  parameter int ID_W      = 5,
  parameter int IDX_W     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  cost_eval_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FWD, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q;
  logic [ID_W-1:0]           arg_q, my_q, dest_q;
  logic [NUM_SINKS*ID_W-1:0] sinks_q;
  logic [NUM_SINKS-1:0]      valid_q;
  logic                      iam_sink_q, iam_fwd_q, done_q, done_d, busy_d;
  logic [IDX_W-1:0]          sink_index_q;

  logic [ID_W-1:0]           entry;
  logic                      hit, last, accept;

  // Current table entry compare and pass-control qualifiers
  always_comb begin
    entry  = sinks_q[ID_W*idx_q +: ID_W];
    hit    = valid_q[idx_q] && (entry == arg_q);
    last   = (idx_q == IDX_W'(NUM_SINKS - 1));
    accept = (state_q == S_IDLE) && bus.start && !bus.abort;
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort beats start and beats a scan hit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_SCAN;
      S_SCAN: begin
        if (bus.abort)       state_d = S_IDLE;
        else if (hit || last) state_d = S_FWD;
      end
      S_FWD:  state_d = bus.abort ? S_IDLE : S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; done is registered so it appears the cycle after DONE
  always_comb begin
    busy_d = (state_q == S_SCAN) || (state_q == S_FWD);
    done_d = (state_q == S_DONE);
  end

  // Request shadow registers, scan index and result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q        <= '0;
      arg_q        <= '0;
      my_q         <= '0;
      dest_q       <= '0;
      sinks_q      <= '0;
      valid_q      <= '0;
      iam_sink_q   <= 1'b0;
      iam_fwd_q    <= 1'b0;
      sink_index_q <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= done_d;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            arg_q        <= bus.arg_id;
            my_q         <= bus.my_node_id;
            dest_q       <= bus.dest_id;
            sinks_q      <= bus.known_sinks;
            valid_q      <= bus.sink_valid;
            iam_sink_q   <= 1'b0;
            iam_fwd_q    <= 1'b0;
            sink_index_q <= '0;
            idx_q        <= '0;
          end
        end
        S_SCAN: begin
          if (bus.abort) begin
            iam_sink_q   <= 1'b0;
            iam_fwd_q    <= 1'b0;
            sink_index_q <= '0;
            idx_q        <= '0;
          end else if (hit) begin
            iam_sink_q   <= 1'b1;
            sink_index_q <= idx_q;
          end else if (!last) begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_FWD: begin
          if (bus.abort) begin
            iam_sink_q   <= 1'b0;
            iam_fwd_q    <= 1'b0;
            sink_index_q <= '0;
            idx_q        <= '0;
          end else begin
            iam_fwd_q <= !iam_sink_q && (my_q == dest_q);
          end
        end
        default: ;
      endcase
    end
  end

  // Drive the result side of the bundle
  always_comb begin
    bus.busy           = busy_d;
    bus.done           = done_q;
    bus.iam_sink       = iam_sink_q;
    bus.iam_forwarding = iam_fwd_q;
    bus.sink_index     = sink_index_q;
  end

endmodule

// File: tb/tb_cost_eval_sequencer.sv
// Self-checking bench for cost_eval_sequencer: directed scenarios plus
// randomized passes against a table-scan reference model.
module tb_cost_eval_sequencer;
  localparam int NS = 10;
  localparam int IW = 5;
  localparam int XW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [IW-1:0] tab [NS];
  logic [NS-1:0] vld;

  cost_eval_sequencer_if #(.NUM_SINKS(NS), .ID_W(IW), .IDX_W(XW)) bus();

  cost_eval_sequencer #(.NUM_SINKS(NS), .ID_W(IW), .IDX_W(XW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Expected outcome: first valid entry equal to arg wins; latency counted
  // in edges from the accept edge to the edge after which done is high.
  function automatic void model(input logic [IW-1:0] a, m, d, output int lat,
                                output logic s, output logic [XW-1:0] ix,
                                output logic f);
    s = 1'b0; ix = '0; lat = NS + 2;
    for (int i = 0; i < NS; i++)
      if (!s && vld[i] && tab[i] == a) begin s = 1'b1; ix = XW'(i); lat = i + 3; end
    f = !s && (m == d);
  endfunction

  task automatic drive_req(input logic [IW-1:0] a, m, d);
    bus.arg_id     = a;
    bus.my_node_id = m;
    bus.dest_id    = d;
    for (int i = 0; i < NS; i++) bus.known_sinks[IW*i +: IW] = tab[i];
    bus.sink_valid = vld;
  endtask

  // Launch one pass and observe it; optional extra start pulse and input churn
  task automatic run_pass(input logic [IW-1:0] a, m, d, input int pulse_at,
                          input bit mutate, output int lat, output logic s,
                          output logic [XW-1:0] ix, output logic f,
                          output int extra_done, output bit hold_ok,
                          output logic busy_first);
    @(negedge clock);
    drive_req(a, m, d);
    bus.start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.start  = 1'b0;
    busy_first = bus.busy;
    if (mutate) begin
      for (int i = 0; i < NS; i++) tab[i] = IW'($urandom);
      vld = NS'($urandom);
      drive_req(IW'($urandom), IW'($urandom), IW'($urandom));
    end
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus.done) begin lat = n; break; end
      bus.start = (n == pulse_at);
    end
    bus.start = 1'b0;
    s = bus.iam_sink; ix = bus.sink_index; f = bus.iam_forwarding;
    extra_done = 0; hold_ok = 1'b1;
    repeat (16) begin
      @(negedge clock);
      if (bus.done) extra_done++;
      if (bus.iam_sink !== s || bus.sink_index !== ix || bus.iam_forwarding !== f)
        hold_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({bus.busy, bus.done, bus.iam_sink, bus.iam_forwarding, bus.sink_index} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b sink=%b fwd=%b idx=%0d want all 0",
               bus.busy, bus.done, bus.iam_sink, bus.iam_forwarding, bus.sink_index);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_directed();
    logic [IW-1:0] a, m, d;
    int pulse, lat, elat, xd;
    bit mut, hold;
    logic s, f, es, ef, bf;
    logic [XW-1:0] ix, eix;
    for (int c = 0; c < 7; c++) begin
      for (int i = 0; i < NS; i++) tab[i] = IW'(i);
      vld = '1; a = 5'd1; m = 5'd3; d = 5'd3; pulse = 0; mut = 1'b0;
      case (c)
        1: a = 5'd31;
        2: begin a = 5'd31; d = 5'd4; end
        3: vld = 10'b11_1111_1101;
        4: begin tab[2] = 5'd9; tab[7] = 5'd9; a = 5'd9; pulse = 1; end
        5: a = 5'd9;
        6: mut = 1'b1;
        default: ;
      endcase
      model(a, m, d, elat, es, eix, ef);
      run_pass(a, m, d, pulse, mut, lat, s, ix, f, xd, hold, bf);
      checks += 6;
      if (lat !== elat) begin errors++; $display("FAIL dir_latency case %0d: got %0d want %0d", c, lat, elat); end
      if (s !== es) begin errors++; $display("FAIL dir_iam_sink case %0d: got %b want %b", c, s, es); end
      if (ix !== eix) begin errors++; $display("FAIL dir_sink_index case %0d: got %0d want %0d", c, ix, eix); end
      if (f !== ef) begin errors++; $display("FAIL dir_iam_fwd case %0d: got %b want %b", c, f, ef); end
      if (xd !== 0 || !hold) begin errors++; $display("FAIL dir_single_done_hold case %0d: extra done %0d hold %b want 0 1", c, xd, hold); end
      if (bf !== 1'b1) begin errors++; $display("FAIL dir_busy case %0d: got %b want 1", c, bf); end
    end
  endtask

  task automatic test_random();
    logic [IW-1:0] a, m, d;
    int pulse, lat, elat, xd;
    bit mut, hold;
    logic s, f, es, ef, bf;
    logic [XW-1:0] ix, eix;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NS; i++) tab[i] = IW'($urandom_range(0, 7));
      vld   = NS'($urandom);
      a     = ($urandom_range(0, 5) == 0) ? IW'($urandom) : IW'($urandom_range(0, 7));
      m     = IW'($urandom_range(0, 3));
      d     = IW'($urandom_range(0, 3));
      pulse = $urandom_range(0, 3);
      mut   = 1'($urandom_range(0, 1));
      model(a, m, d, elat, es, eix, ef);
      run_pass(a, m, d, pulse, mut, lat, s, ix, f, xd, hold, bf);
      checks++;
      if (lat !== elat || s !== es || ix !== eix || f !== ef || xd !== 0 || !hold) begin
        errors++;
        $display("FAIL rand_pass %0d: got lat=%0d sink=%b idx=%0d fwd=%b xdone=%0d hold=%b want lat=%0d sink=%b idx=%0d fwd=%b xdone=0 hold=1",
                 r, lat, s, ix, f, xd, hold, elat, es, eix, ef);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int nd;
    for (int i = 0; i < NS; i++) tab[i] = IW'(i);
    vld = '1;
    @(negedge clock);
    drive_req(5'd31, 5'd3, 5'd3);
    bus.start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    repeat (4) begin @(posedge clock); @(negedge clock); end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.iam_sink, bus.iam_forwarding, bus.sink_index} !== '0) begin
      errors++;
      $display("FAIL reset_mid_scan: got busy=%b done=%b sink=%b fwd=%b idx=%0d want all 0",
               bus.busy, bus.done, bus.iam_sink, bus.iam_forwarding, bus.sink_index);
    end
    @(negedge clock);
    reset = 1'b0;
    nd = 0;
    repeat (16) begin @(negedge clock); if (bus.done || bus.busy) nd++; end
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL reset_no_done: got %0d busy/done cycles want 0", nd); end
  endtask

  task automatic test_abort();
    int nd, lat, elat, xd;
    bit hold;
    logic s, f, es, ef, bf;
    logic [XW-1:0] ix, eix;
    for (int i = 0; i < NS; i++) tab[i] = IW'(i);
    vld = '1;
    // Abort in FWD after a hit at index 1: the hit must be discarded
    @(negedge clock);
    drive_req(5'd1, 5'd3, 5'd3);
    bus.start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    repeat (2) begin @(posedge clock); @(negedge clock); end
    checks++;
    if (bus.busy !== 1'b1 || bus.iam_sink !== 1'b1) begin
      errors++; $display("FAIL abort_pre_fwd: got busy=%b sink=%b want 1 1", bus.busy, bus.iam_sink);
    end
    bus.abort = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.abort = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.iam_sink, bus.iam_forwarding, bus.sink_index} !== '0) begin
      errors++;
      $display("FAIL abort_fwd_clear: got busy=%b done=%b sink=%b fwd=%b idx=%0d want all 0",
               bus.busy, bus.done, bus.iam_sink, bus.iam_forwarding, bus.sink_index);
    end
    nd = 0;
    repeat (16) begin @(negedge clock); if (bus.done) nd++; end
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL abort_fwd_no_done: got %0d dones want 0", nd); end
    // Next start runs normally
    model(5'd1, 5'd3, 5'd3, elat, es, eix, ef);
    run_pass(5'd1, 5'd3, 5'd3, 0, 1'b0, lat, s, ix, f, xd, hold, bf);
    checks++;
    if (lat !== elat || s !== es || ix !== eix || f !== ef || xd !== 0) begin
      errors++;
      $display("FAIL abort_then_pass: got lat=%0d sink=%b idx=%0d fwd=%b want lat=%0d sink=%b idx=%0d fwd=%b",
               lat, s, ix, f, elat, es, eix, ef);
    end
    // Abort in SCAN with no match
    @(negedge clock);
    drive_req(5'd31, 5'd3, 5'd3);
    bus.start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    repeat (2) begin @(posedge clock); @(negedge clock); end
    bus.abort = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.abort = 1'b0;
    nd = 0;
    repeat (16) begin @(negedge clock); if (bus.done || bus.busy || bus.iam_forwarding) nd++; end
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL abort_scan: got %0d active cycles want 0", nd); end
    // abort together with start in IDLE: nothing accepted
    @(negedge clock);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    nd = 0;
    repeat (16) begin if (bus.busy || bus.done) nd++; @(negedge clock); end
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL abort_start_idle: got %0d active cycles want 0", nd); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int i = 0; i < NS; i++) tab[i] = '0;
    vld = '0;
    drive_req('0, '0, '0);
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_scan();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
